// File: rtl/sp_ram_param.sv
// -----------------------------------------------------------------------------
// sp_ram_param
//
// Parametrised single-port synchronous RAM with a hardware clear sequencer.
// After every reset the sequencer sweeps the whole array and writes zero to
// each location, one location per clock. While the sweep runs, busy is high
// and all accesses are ignored. The RAM therefore always starts from a known
// all-zero state.
//
// Parameters
//   DATA_W   data width in bits (>= 1)
//   ADDR_W   address width; DEPTH = 2**ADDR_W locations
//   WR_MODE  data returned on a write access:
//              0 read-first  (old contents, rvalid=1)
//              1 write-first (new data,     rvalid=1)
//              2 no-change   (rdata holds,  rvalid=0)
//   OUT_REG  1 adds a pipeline register on rdata/rvalid (+1 cycle latency)
//
// Ports
//   clk     in   1       clock, rising edge
//   rst     in   1       synchronous, active-high reset
//   en      in   1       access enable
//   we      in   1       1 = write, 0 = read (qualified by en)
//   addr    in   ADDR_W  location
//   wdata   in   DATA_W  write data
//   rdata   out  DATA_W  read data (holds between accesses)
//   rvalid  out  1       one-cycle strobe: rdata updated by an access
//   busy    out  1       clear sweep in progress; accesses are ignored
// -----------------------------------------------------------------------------
module sp_ram_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int WR_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    // The clear pointer is one bit wider than the address so that it
    // never wraps; the sweep ends when it holds the last address.
    localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PTR_LAST = {1'b0, {ADDR_W{1'b1}}};

    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    localparam logic [1:0] WR_MODE_L = WR_MODE[1:0];

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    state_e            state_q;
    logic [ADDR_W:0]   clr_ptr_q;
    logic              busy_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    // -------------------------------------------------------------------------
    // Access decode and memory write port
    // -------------------------------------------------------------------------
    logic              acc_s;
    logic              acc_wr_s;
    logic              acc_rd_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] mem_rdata_s;

    // Qualify user accesses: only in READY with the sweep finished.
    always_comb begin
        acc_s    = (state_q == ST_READY) && en && !busy_q;
        acc_wr_s = acc_s && we;
        acc_rd_s = acc_s && !we;
    end

    // The array is read before the edge, so a write cycle sees the old
    // contents here (needed for read-first mode).
    assign mem_rdata_s = mem_q[addr];

    // Select the single write port source: the clear sweep or a user write.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {ADDR_W{1'b0}};
        mem_wdata_s = DATA_ZERO;
        if (rst) begin
            // Memory is left untouched while reset is held.
            mem_we_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_ptr_q[ADDR_W-1:0];
            mem_wdata_s = DATA_ZERO;
        end else if (acc_wr_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = addr;
            mem_wdata_s = wdata;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; no reset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered rdata/rvalid/busy
    // -------------------------------------------------------------------------
    // CLEAR sweeps every location, READY serves accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= PTR_ZERO;
            busy_q    <= 1'b1;
            rdata_q   <= DATA_ZERO;
            rvalid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // rdata holds its last value; only the strobe is dropped.
                    rvalid_q  <= 1'b0;
                    clr_ptr_q <= clr_ptr_q + PTR_ONE;
                    if (clr_ptr_q == PTR_LAST) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (acc_wr_s) begin
                        case (WR_MODE_L)
                            2'd0: begin
                                rdata_q  <= mem_rdata_s;
                                rvalid_q <= 1'b1;
                            end
                            2'd1: begin
                                rdata_q  <= wdata;
                                rvalid_q <= 1'b1;
                            end
                            default: begin
                                // No-change: rdata keeps the previous read.
                                rvalid_q <= 1'b0;
                            end
                        endcase
                    end else if (acc_rd_s) begin
                        rdata_q  <= mem_rdata_s;
                        rvalid_q <= 1'b1;
                    end else begin
                        rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover by restarting the sweep.
                    state_q   <= ST_CLEAR;
                    clr_ptr_q <= PTR_ZERO;
                    busy_q    <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // -------------------------------------------------------------------------
    // Optional output pipeline stage
    // -------------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] rdata_p_q;
        logic              rvalid_p_q;

        // Delay rdata/rvalid by one cycle; zeroed by reset like the first stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_p_q  <= DATA_ZERO;
                rvalid_p_q <= 1'b0;
            end else begin
                rdata_p_q  <= rdata_q;
                rvalid_p_q <= rvalid_q;
            end
        end

        assign rdata  = rdata_p_q;
        assign rvalid = rvalid_p_q;
    end else begin : g_out_direct
        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_sp_ram_param.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_param
//
// Three instances share one stimulus stream:
//   u_rf : WR_MODE=0 (read-first),  OUT_REG=0
//   u_wf : WR_MODE=1 (write-first), OUT_REG=1
//   u_nc : WR_MODE=2 (no-change),   OUT_REG=0
// A behavioural model (array plus a clear countdown) predicts each output
// after every clock edge.
// -----------------------------------------------------------------------------
module tb_sp_ram_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    logic [DW-1:0] rd_rf, rd_wf, rd_nc;
    logic          rv_rf, rv_wf, rv_nc;
    logic          bz_rf, bz_wf, bz_nc;

    sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .WR_MODE(0), .OUT_REG(0)) u_rf (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rd_rf), .rvalid(rv_rf), .busy(bz_rf)
    );

    sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .WR_MODE(1), .OUT_REG(1)) u_wf (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rd_wf), .rvalid(rv_wf), .busy(bz_wf)
    );

    sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .WR_MODE(2), .OUT_REG(0)) u_nc (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rd_nc), .rvalid(rv_nc), .busy(bz_nc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left;          // clear cycles still to run
    logic          m_busy;
    logic [DW-1:0] m_rd [3];        // first-stage rdata per write mode
    logic          m_rv [3];
    logic [DW-1:0] m_prd;           // output stage of the OUT_REG=1 instance
    logic          m_prv;
    bit            m_live = 1'b0;   // set once the first reset has been applied

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Effect of one clock edge, from the behavioural rules.
    task automatic model_edge(input logic r, input logic e, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] old;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_left = DEPTH;
            m_busy = 1'b1;
            for (int k = 0; k < 3; k++) begin
                m_rd[k] = '0;
                m_rv[k] = 1'b0;
            end
            m_prd  = '0;
            m_prv  = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            m_prd = m_rd[1];
            m_prv = m_rv[1];
            if (m_busy) begin
                m_left = m_left - 1;
                m_busy = (m_left != 0);
                for (int k = 0; k < 3; k++) m_rv[k] = 1'b0;
            end else if (e && w) begin
                old      = m_mem[a];
                m_mem[a] = d;
                m_rd[0]  = old;
                m_rv[0]  = 1'b1;
                m_rd[1]  = d;
                m_rv[1]  = 1'b1;
                m_rv[2]  = 1'b0;
            end else if (e) begin
                for (int k = 0; k < 3; k++) begin
                    m_rd[k] = m_mem[a];
                    m_rv[k] = 1'b1;
                end
            end else begin
                for (int k = 0; k < 3; k++) m_rv[k] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, take the edge, then compare every output.
    task automatic cyc(input logic r, input logic e, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst   = r;
        en    = e;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        model_edge(r, e, w, a, d);
        if (m_live) begin
            chk("busy_rf",   {31'd0, bz_rf}, {31'd0, m_busy});
            chk("busy_wf",   {31'd0, bz_wf}, {31'd0, m_busy});
            chk("busy_nc",   {31'd0, bz_nc}, {31'd0, m_busy});
            chk("rdata_rf",  {24'd0, rd_rf}, {24'd0, m_rd[0]});
            chk("rvalid_rf", {31'd0, rv_rf}, {31'd0, m_rv[0]});
            chk("rdata_wf",  {24'd0, rd_wf}, {24'd0, m_prd});
            chk("rvalid_wf", {31'd0, rv_wf}, {31'd0, m_prv});
            chk("rdata_nc",  {24'd0, rd_nc}, {24'd0, m_rd[2]});
            chk("rvalid_nc", {31'd0, rv_nc}, {31'd0, m_rv[2]});
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    initial begin
        int          cnt;
        logic [31:0] rnd;
        logic [31:0] ri;

        rst   = 1'b0;
        en    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;

        // One reset cycle, then the sweep; accesses attempted throughout.
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        chk("rst_busy",   {31'd0, bz_rf}, 32'd1);
        chk("rst_rdata",  {24'd0, rd_wf}, 32'd0);
        chk("rst_rvalid", {31'd0, rv_rf}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40 && bz_rf === 1'b1; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 4'd0, 8'hFF);
            chk("busy_write_ignored", {31'd0, rv_rf}, 32'd0);
            cnt++;
        end
        chk("busy_len", cnt, 32'd16);

        // Every location reads zero, including the one written during busy.
        for (int i = 0; i < DEPTH; i++) begin
            ri = i;
            cyc(1'b0, 1'b1, 1'b0, ri[3:0], 8'd0);
            chk("clear_read", {24'd0, rd_rf}, 32'd0);
            chk("clear_rvalid", {31'd0, rv_rf}, 32'd1);
        end

        // Write A5 @3, read it back.
        cyc(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5);
        cyc(1'b0, 1'b1, 1'b0, 4'd3, 8'd0);
        chk("raw_rf", {24'd0, rd_rf}, 32'hA5);
        chk("raw_nc", {24'd0, rd_nc}, 32'hA5);
        idle();
        chk("raw_wf_lat2", {24'd0, rd_wf}, 32'hA5);
        chk("raw_wf_rv",   {31'd0, rv_wf}, 32'd1);

        // Overwrite with 5A: the three write modes differ.
        cyc(1'b0, 1'b1, 1'b1, 4'd3, 8'h5A);
        chk("wm0_old",  {24'd0, rd_rf}, 32'hA5);
        chk("wm0_rv",   {31'd0, rv_rf}, 32'd1);
        chk("wm2_hold", {24'd0, rd_nc}, 32'hA5);
        chk("wm2_rv",   {31'd0, rv_nc}, 32'd0);
        idle();
        chk("wm1_new",  {24'd0, rd_wf}, 32'h5A);
        chk("wm1_rv",   {31'd0, rv_wf}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'd3, 8'd0);
        chk("rd3_rf", {24'd0, rd_rf}, 32'h5A);
        chk("rd3_nc", {24'd0, rd_nc}, 32'h5A);
        idle();
        chk("rd3_wf", {24'd0, rd_wf}, 32'h5A);

        // Reset five cycles into the sweep restarts it from location 0.
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        for (int i = 0; i < 5; i++) idle();
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        cnt = 0;
        for (int i = 0; i < 40 && bz_rf === 1'b1; i++) begin
            idle();
            cnt++;
        end
        chk("busy_len_restart", cnt, 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            ri = i;
            cyc(1'b0, 1'b1, 1'b0, ri[3:0], 8'd0);
            chk("restart_read", {24'd0, rd_rf}, 32'd0);
        end

        // Fill with random data, then stream reads with a two-cycle gap.
        for (int i = 0; i < DEPTH; i++) begin
            ri  = i;
            rnd = $urandom;
            cyc(1'b0, 1'b1, 1'b1, ri[3:0], rnd[7:0]);
        end
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ri = i;
            if (i == 8) begin
                idle();
                chk("gap_rv", {31'd0, rv_rf}, 32'd0);
                idle();
                chk("gap_rv2", {31'd0, rv_rf}, 32'd0);
            end
            cyc(1'b0, 1'b1, 1'b0, ri[3:0], 8'd0);
            if (rv_rf === 1'b1) cnt++;
        end
        chk("stream_strobes", cnt, 32'd16);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rnd = $urandom;
            cyc(rnd[31:25] == 7'd0, rnd[1:0] != 2'd0, rnd[2],
                rnd[3] ? {2'b00, rnd[5:4]} : rnd[7:4], rnd[15:8]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
